// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: FSM state/phase enums, bus-level constants
// and the default CPLD target address.
package i2c_pkg;

  // Byte-level protocol state of the target.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_PTR,
    ST_WDATA,
    ST_RDATA
  } i2c_tgt_state_t;

  // Position within a byte: data bits, waiting for the ACK slot, inside the ACK slot.
  typedef enum logic [1:0] {
    PH_BITS,
    PH_ACK_WAIT,
    PH_ACK_DRIVE
  } i2c_tgt_phase_t;

  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic [6:0] I2C_CPLD_ADDR = 7'b0111110;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-FF synchronisers for SCL/SDA plus edge and START/STOP strobes.
// Ports:
//   CLK, rst_n          clock, synchronous active-low reset
//   scl_o, sda_o        raw pin values from the IOBUF
//   scl_s, sda_s        synchronised line levels
//   scl_rise_c/_fall_c  one-cycle SCL edge strobes
//   start_c / stop_c    one-cycle START / STOP strobes
module i2c_line_sync (
  input  logic CLK,
  input  logic rst_n,
  input  logic scl_o,
  input  logic sda_o,
  output logic scl_s,
  output logic sda_s,
  output logic scl_rise_c,
  output logic scl_fall_c,
  output logic start_c,
  output logic stop_c
);

  logic scl_meta, sda_meta;
  logic scl_prev, sda_prev;

  // Reset to the idle-high bus level so no edge is seen leaving reset.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      scl_meta <= 1'b1;
      sda_meta <= 1'b1;
      scl_s    <= 1'b1;
      sda_s    <= 1'b1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_meta <= scl_o;
      sda_meta <= sda_o;
      scl_s    <= scl_meta;
      sda_s    <= sda_meta;
      scl_prev <= scl_s;
      sda_prev <= sda_s;
    end
  end

  assign scl_rise_c = scl_s & ~scl_prev;
  assign scl_fall_c = ~scl_s & scl_prev;
  // SCL must be high on both samples so an SCL edge never looks like START/STOP.
  assign start_c    = scl_s & scl_prev & sda_prev & ~sda_s;
  assign stop_c     = scl_s & scl_prev & ~sda_prev & sda_s;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target on a single 7-bit address exposing NUM_REGS 8-bit registers.
// Write: START, addr+W, pointer, data... ; read: START, addr+R, data...
// Optional bus-stuck timeout enabled by defining I2C_TGT_TIMEOUT_EN.
// Ports:
//   CLK, rst_n      clock, synchronous active-low reset
//   scl_o, sda_o    SCL/SDA pin values from the IOBUF
//   sda_i           SDA drive value (always 0, open-drain)
//   sda_t           1 = pull SDA low
//   regs_q          register file, reg k at [8k+7:8k]
//   wr_pulse        one-cycle strobe per committed write
//   wr_ptr          register index of that write
//   busy            high from START until STOP or abort
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TGT_ADDR       = I2C_CPLD_ADDR,
  parameter int unsigned NUM_REGS       = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  input  logic                  scl_o,
  input  logic                  sda_o,
  output logic                  sda_i,
  output logic                  sda_t,
  output logic [8*NUM_REGS-1:0] regs_q,
  output logic                  wr_pulse,
  output logic [7:0]            wr_ptr,
  output logic                  busy
);

  localparam int unsigned IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [7:0]  NUM_REGS_B = 8'(NUM_REGS);

  if (NUM_REGS < 1 || NUM_REGS > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("i2c_target_regs: NUM_REGS must be 1..16 and TIMEOUT_CYCLES >= 1");
  end

  logic scl_s, sda_s, scl_rise_c, scl_fall_c, start_c, stop_c, timeout_c;

  i2c_line_sync u_sync (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .scl_o      (scl_o),
    .sda_o      (sda_o),
    .scl_s      (scl_s),
    .sda_s      (sda_s),
    .scl_rise_c (scl_rise_c),
    .scl_fall_c (scl_fall_c),
    .start_c    (start_c),
    .stop_c     (stop_c)
  );

  i2c_tgt_state_t state;
  i2c_tgt_phase_t phase;
  logic [2:0]     bit_cnt;
  logic [6:0]     shreg;
  logic [7:0]     tx;
  logic [7:0]     pointer;
  logic           ack_q;
  logic           rw_q;
  logic [7:0]     regs [NUM_REGS];

  logic [7:0] rx_byte_c, ptr_inc_c, rd_cur_c, rd_nxt_c;
  logic       ptr_valid_c;

  assign sda_i     = 1'b0;
  assign rx_byte_c = {shreg, sda_s};
  assign ptr_inc_c = pointer + 8'd1;
  assign ptr_valid_c = (pointer < NUM_REGS_B);

  // Read data for the current and the next pointer; out-of-range reads as 0xFF.
  always_comb begin
    rd_cur_c = 8'hFF;
    rd_nxt_c = 8'hFF;
    if (pointer < NUM_REGS_B)   rd_cur_c = regs[pointer[IDX_W-1:0]];
    if (ptr_inc_c < NUM_REGS_B) rd_nxt_c = regs[ptr_inc_c[IDX_W-1:0]];
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs_out
    assign regs_q[8*k +: 8] = regs[k];
  end

`ifdef I2C_TGT_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;

  // Counts consecutive cycles of SCL held low during a transfer.
  always_ff @(posedge CLK) begin
    if (!rst_n)              to_cnt <= '0;
    else if (busy && !scl_s) to_cnt <= to_cnt + TO_W'(1);
    else                     to_cnt <= '0;
  end

  assign timeout_c = busy && !scl_s && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_c = 1'b0;
`endif

  // Protocol FSM; START/STOP/timeout override every state.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      phase    <= PH_BITS;
      bit_cnt  <= 3'd7;
      shreg    <= '0;
      tx       <= '0;
      pointer  <= '0;
      ack_q    <= I2C_NACK;
      rw_q     <= I2C_RW_WRITE;
      sda_t    <= 1'b0;
      wr_pulse <= 1'b0;
      wr_ptr   <= '0;
      busy     <= 1'b0;
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      wr_pulse <= 1'b0;
      if (start_c) begin
        state   <= ST_ADDR;
        phase   <= PH_BITS;
        bit_cnt <= 3'd7;
        busy    <= 1'b1;
        sda_t   <= 1'b0;
      end else if (stop_c || timeout_c) begin
        state <= ST_IDLE;
        phase <= PH_BITS;
        busy  <= 1'b0;
        sda_t <= 1'b0;
      end else begin
        case (state)
          ST_ADDR, ST_PTR, ST_WDATA: begin
            case (phase)
              PH_BITS: if (scl_rise_c) begin
                shreg   <= rx_byte_c[6:0];
                bit_cnt <= bit_cnt - 3'd1;
                if (bit_cnt == 3'd0) begin
                  phase <= PH_ACK_WAIT;
                  if (state == ST_ADDR) begin
                    if (rx_byte_c[7:1] == TGT_ADDR) begin
                      ack_q <= I2C_ACK;
                      rw_q  <= rx_byte_c[0];
                    end else begin
                      state <= ST_IDLE;
                      phase <= PH_BITS;
                    end
                  end else if (state == ST_PTR) begin
                    pointer <= rx_byte_c;
                    ack_q   <= I2C_ACK;
                  end else begin
                    if (ptr_valid_c) begin
                      regs[pointer[IDX_W-1:0]] <= rx_byte_c;
                      wr_pulse <= 1'b1;
                      wr_ptr   <= pointer;
                      ack_q    <= I2C_ACK;
                    end else begin
                      ack_q <= I2C_NACK;
                    end
                    pointer <= ptr_inc_c;
                  end
                end
              end
              PH_ACK_WAIT: if (scl_fall_c) begin
                sda_t <= (ack_q == I2C_ACK);
                phase <= PH_ACK_DRIVE;
              end
              default: if (scl_fall_c) begin
                // The fall ending the ACK slot also presents read bit 7.
                bit_cnt <= 3'd7;
                phase   <= PH_BITS;
                if (state == ST_ADDR && rw_q == I2C_RW_READ) begin
                  state <= ST_RDATA;
                  tx    <= rd_cur_c;
                  sda_t <= ~rd_cur_c[7];
                end else begin
                  sda_t <= 1'b0;
                  if (state == ST_ADDR && rw_q == I2C_RW_WRITE) state <= ST_PTR;
                  else if (state == ST_PTR)                     state <= ST_WDATA;
                end
              end
            endcase
          end
          ST_RDATA: begin
            case (phase)
              PH_BITS: if (scl_fall_c) begin
                if (bit_cnt == 3'd0) begin
                  sda_t <= 1'b0;
                  phase <= PH_ACK_WAIT;
                end else begin
                  sda_t   <= ~tx[bit_cnt - 3'd1];
                  bit_cnt <= bit_cnt - 3'd1;
                end
              end
              PH_ACK_WAIT: if (scl_rise_c) begin
                if (sda_s == I2C_ACK) begin
                  pointer <= ptr_inc_c;
                  tx      <= rd_nxt_c;
                  phase   <= PH_ACK_DRIVE;
                end else begin
                  state <= ST_IDLE;
                  phase <= PH_BITS;
                end
              end
              default: if (scl_fall_c) begin
                sda_t   <= ~tx[7];
                bit_cnt <= 3'd7;
                phase   <= PH_BITS;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: bit-banged I2C master with an
// open-drain SDA model. Timeout scenario runs only with I2C_TGT_TIMEOUT_EN.
module tb_i2c_target_regs;

  localparam int unsigned Q = 10;  // CLK cycles per quarter SCL period

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        sda_pin;
  logic        sda_i, sda_t, wr_pulse, busy;
  logic [31:0] regs_q;
  logic [7:0]  wr_ptr;

  int checks = 0;
  int errors = 0;

  int         wr_cnt = 0;
  logic [7:0] last_wr_ptr = 8'h00;
  int         drive_cnt = 0;

  always #5 CLK = ~CLK;

  assign sda_pin = sda_t ? (m_sda & sda_i) : m_sda;

  i2c_target_regs #(
    .TGT_ADDR       (7'b0111110),
    .NUM_REGS       (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .scl_o    (m_scl),
    .sda_o    (sda_pin),
    .sda_i    (sda_i),
    .sda_t    (sda_t),
    .regs_q   (regs_q),
    .wr_pulse (wr_pulse),
    .wr_ptr   (wr_ptr),
    .busy     (busy)
  );

  always @(posedge CLK) begin
    if (wr_pulse) begin
      wr_cnt      <= wr_cnt + 1;
      last_wr_ptr <= wr_ptr;
    end
    if (sda_t) drive_cnt <= drive_cnt + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_rstart();
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b1; wait_clk(Q);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    m_sda = b; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    s = sda_pin; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic read_byte(input logic mnack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
    end
    clock_bit(mnack, s);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clk(5);
    checks += 6;
    if (sda_t !== 1'b0)     begin errors++; $display("FAIL reset_sda_t got %b exp 0", sda_t); end
    if (sda_i !== 1'b0)     begin errors++; $display("FAIL reset_sda_i got %b exp 0", sda_i); end
    if (regs_q !== 32'h0)   begin errors++; $display("FAIL reset_regs got %h exp 00000000", regs_q); end
    if (wr_pulse !== 1'b0)  begin errors++; $display("FAIL reset_wr_pulse got %b exp 0", wr_pulse); end
    if (wr_ptr !== 8'h00)   begin errors++; $display("FAIL reset_wr_ptr got %h exp 00", wr_ptr); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    rst_n = 1'b1;
    wait_clk(5);
  endtask

  task automatic test_write();
    logic a0, a1, a2;
    int w0;
    w0 = wr_cnt;
    i2c_start();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL write_busy_start got %b exp 1", busy); end
    write_byte(8'h7C, a0);
    write_byte(8'h02, a1);
    write_byte(8'h01, a2);
    i2c_stop();
    checks += 7;
    if (a0 !== 1'b1) begin errors++; $display("FAIL write_ack_addr got %b exp 1", a0); end
    if (a1 !== 1'b1) begin errors++; $display("FAIL write_ack_ptr got %b exp 1", a1); end
    if (a2 !== 1'b1) begin errors++; $display("FAIL write_ack_data got %b exp 1", a2); end
    if (regs_q !== 32'h0001_0000) begin errors++; $display("FAIL write_regs got %h exp 00010000", regs_q); end
    if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL write_pulse_count got %0d exp 1", wr_cnt - w0); end
    if (last_wr_ptr !== 8'h02) begin errors++; $display("FAIL write_wr_ptr got %h exp 02", last_wr_ptr); end
    if (busy !== 1'b0) begin errors++; $display("FAIL write_busy_stop got %b exp 0", busy); end
  endtask

  task automatic test_wrong_addr();
    logic a0, a1;
    int w0, d0;
    w0 = wr_cnt;
    d0 = drive_cnt;
    i2c_start();
    write_byte(8'h70, a0);
    write_byte(8'h00, a1);
    i2c_stop();
    checks += 5;
    if (a0 !== 1'b0) begin errors++; $display("FAIL wrong_addr_ack0 got %b exp 0", a0); end
    if (a1 !== 1'b0) begin errors++; $display("FAIL wrong_addr_ack1 got %b exp 0", a1); end
    if (drive_cnt - d0 !== 0) begin errors++; $display("FAIL wrong_addr_sda_drive got %0d exp 0", drive_cnt - d0); end
    if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL wrong_addr_pulse got %0d exp 0", wr_cnt - w0); end
    if (regs_q !== 32'h0001_0000) begin errors++; $display("FAIL wrong_addr_regs got %h exp 00010000", regs_q); end
  endtask

  task automatic test_read();
    logic a0, a1, a2, a3, a4;
    logic [7:0] d0, d1;
    int w0;
    w0 = wr_cnt;
    // preload reg2=A5, reg3=3C via auto-increment
    i2c_start();
    write_byte(8'h7C, a0);
    write_byte(8'h02, a1);
    write_byte(8'hA5, a2);
    write_byte(8'h3C, a3);
    i2c_stop();
    checks += 4;
    if ({a0, a1, a2, a3} !== 4'b1111) begin errors++; $display("FAIL preload_acks got %b exp 1111", {a0, a1, a2, a3}); end
    if (regs_q !== 32'h3CA5_0000) begin errors++; $display("FAIL preload_regs got %h exp 3ca50000", regs_q); end
    if (wr_cnt - w0 !== 2) begin errors++; $display("FAIL preload_pulses got %0d exp 2", wr_cnt - w0); end
    if (last_wr_ptr !== 8'h03) begin errors++; $display("FAIL preload_wr_ptr got %h exp 03", last_wr_ptr); end

    i2c_start();
    write_byte(8'h7C, a0);
    write_byte(8'h02, a1);
    i2c_rstart();
    write_byte(8'h7D, a4);
    read_byte(1'b0, d0);
    read_byte(1'b1, d1);
    checks += 4;
    if ({a0, a1, a4} !== 3'b111) begin errors++; $display("FAIL read_acks got %b exp 111", {a0, a1, a4}); end
    if (d0 !== 8'hA5) begin errors++; $display("FAIL read_byte0 got %h exp a5", d0); end
    if (d1 !== 8'h3C) begin errors++; $display("FAIL read_byte1 got %h exp 3c", d1); end
    if (sda_t !== 1'b0) begin errors++; $display("FAIL read_release got %b exp 0", sda_t); end
    i2c_stop();
  endtask

  task automatic test_out_of_range();
    logic a0, a1, a2, a3;
    logic [7:0] d0;
    int w0;
    w0 = wr_cnt;
    i2c_start();
    write_byte(8'h7C, a0);
    write_byte(8'h05, a1);
    write_byte(8'h55, a2);
    i2c_stop();
    checks += 5;
    if (a0 !== 1'b1) begin errors++; $display("FAIL oor_ack_addr got %b exp 1", a0); end
    if (a1 !== 1'b1) begin errors++; $display("FAIL oor_ack_ptr got %b exp 1", a1); end
    if (a2 !== 1'b0) begin errors++; $display("FAIL oor_data_nack got %b exp 0", a2); end
    if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL oor_pulse got %0d exp 0", wr_cnt - w0); end
    if (regs_q !== 32'h3CA5_0000) begin errors++; $display("FAIL oor_regs got %h exp 3ca50000", regs_q); end

    i2c_start();
    write_byte(8'h7C, a0);
    write_byte(8'h05, a1);
    i2c_rstart();
    write_byte(8'h7D, a3);
    read_byte(1'b1, d0);
    i2c_stop();
    checks++;
    if (d0 !== 8'hFF) begin errors++; $display("FAIL oor_read got %h exp ff", d0); end
  endtask

  task automatic test_reset_abort();
    logic s, a0, a1, a2;
    i2c_start();
    for (int i = 7; i >= 0; i--) clock_bit(((8'h7C >> i) & 8'h01) != 0, s);
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    checks++;
    if (sda_t !== 1'b1) begin errors++; $display("FAIL abort_ack_driven got %b exp 1", sda_t); end
    rst_n = 1'b0;
    wait_clk(1);
    checks += 3;
    if (sda_t !== 1'b0) begin errors++; $display("FAIL abort_sda_t got %b exp 0", sda_t); end
    if (regs_q !== 32'h0) begin errors++; $display("FAIL abort_regs got %h exp 00000000", regs_q); end
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(4);
    m_scl = 1'b0; wait_clk(Q);
    i2c_stop();

    i2c_start();
    write_byte(8'h7C, a0);
    write_byte(8'h01, a1);
    write_byte(8'h5A, a2);
    i2c_stop();
    checks += 2;
    if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL post_abort_acks got %b exp 111", {a0, a1, a2}); end
    if (regs_q !== 32'h0000_5A00) begin errors++; $display("FAIL post_abort_regs got %h exp 00005a00", regs_q); end
  endtask

`ifdef I2C_TGT_TIMEOUT_EN
  task automatic test_timeout();
    logic s, a0;
    i2c_start();
    clock_bit(1'b0, s);
    clock_bit(1'b1, s);
    clock_bit(1'b1, s);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_before got %b exp 1", busy); end
    wait_clk(110);
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got %b exp 0", busy); end
    if (sda_t !== 1'b0) begin errors++; $display("FAIL timeout_sda_t got %b exp 0", sda_t); end
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    i2c_start();
    write_byte(8'h7C, a0);
    i2c_stop();
    checks++;
    if (a0 !== 1'b1) begin errors++; $display("FAIL timeout_recover_ack got %b exp 1", a0); end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_wrong_addr();
    test_read();
    test_out_of_range();
    test_reset_abort();
`ifdef I2C_TGT_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
